// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment driver with per-frame snapshot.
// Define SSD_LZ_BLANK_EN to blank leading zero digits.
module ssd_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000,
  parameter int IDX_W    = $clog2(DIGITS),
  parameter int PRE_W    = $clog2(PRESCALE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  scan_done
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   shadow_dp;
  logic                first;
  logic                tick;
  logic                wrap;
  logic                snap;
  logic [3:0]          nib;
  logic [6:0]          glyph;
`ifdef SSD_LZ_BLANK_EN
  logic                blank;
`endif

  assign tick = en && (pre == PRE_MAX);
  assign wrap = tick && (idx == IDX_MAX);
  assign snap = wrap || !en || first;
  assign nib  = shadow[{idx, 2'b00} +: 4];

`ifdef SSD_LZ_BLANK_EN
  // Digit k>0 is dark when it and every higher nibble are zero.
  assign blank = (idx != '0) &&
                 ((shadow >> {idx, 2'b00}) == '0);
`endif

  // Prescaler and digit index advance only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Frame snapshot: end of scan, while disabled, or right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first     <= 1'b1;
      shadow    <= '0;
      shadow_dp <= '0;
    end else begin
      first <= 1'b0;
      if (snap) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
    end
  end

  // Active-low hex glyph for the nibble of the current digit.
  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
`ifdef SSD_LZ_BLANK_EN
    if (blank) begin
      glyph = 7'h7F;
    end
`endif
  end

  // Registered pin drive; everything dark while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode     <= '1;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      scan_done <= wrap;
      if (en) begin
        anode <= ~(DIGITS'(1) << idx);
        seg   <= glyph;
        dp    <= ~shadow_dp[idx];
      end else begin
        anode <= '1;
        seg   <= 7'h7F;
        dp    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux (DIGITS=4, PRESCALE=4).
// Frame-level model plus directed literal checks.
module tb_ssd_scan_mux;

  localparam int D = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    anode;
  logic [6:0]    seg;
  logic          dp;
  logic          scan_done;

  int vecs = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ssd_scan_mux #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .value(value),
    .dp_in(dp_in),
    .anode(anode),
    .seg(seg),
    .dp(dp),
    .scan_done(scan_done)
  );

  logic [6:0] hex_t [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] glyph(logic [15:0] s, int d);
    logic [15:0] sh;
    sh = s >> (4 * d);
`ifdef SSD_LZ_BLANK_EN
    if (d > 0 && sh == 16'h0) return 7'h7F;
`endif
    return hex_t[sh[3:0]];
  endfunction

  // Model: n counts enabled cycles since reset; the lit digit
  // and the frame boundary follow from plain division.
  int          n;
  bit          m_first;
  logic [15:0] snap;
  logic [3:0]  snap_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_done;
  int          cur_d;
  bit          at_wrap;

  assign cur_d   = (n / P) % D;
  assign at_wrap = en && ((n % (P * D)) == P * D - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       <= 0;
      m_first <= 1'b1;
      snap    <= '0;
      snap_dp <= '0;
      e_an    <= 4'hF;
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
      e_done  <= 1'b0;
    end else begin
      e_done  <= at_wrap;
      m_first <= 1'b0;
      if (en) begin
        e_an  <= ~(4'b0001 << cur_d);
        e_seg <= glyph(snap, cur_d);
        e_dp  <= ~snap_dp[cur_d];
        n     <= n + 1;
      end else begin
        e_an  <= 4'hF;
        e_seg <= 7'h7F;
        e_dp  <= 1'b1;
      end
      if (at_wrap || !en || m_first) begin
        snap    <= value;
        snap_dp <= dp_in;
      end
    end
  end

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic lit(string nm, logic [3:0] an,
                     logic [6:0] sg, logic d);
    vecs++;
    if (anode !== an || seg !== sg || dp !== d) begin
      fails++;
      $display("FAIL %s: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
               nm, anode, seg, dp, an, sg, d);
    end
  endtask

  task automatic lit_done(string nm, logic want);
    vecs++;
    if (scan_done !== want) begin
      fails++;
      $display("FAIL %s: got scan_done=%b want %b",
               nm, scan_done, want);
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (chk_on) begin
          vecs++;
          if (anode !== e_an || seg !== e_seg ||
              dp !== e_dp || scan_done !== e_done) begin
            fails++;
            $display("FAIL cycle t=%0t: got %h/%h/%b/%b want %h/%h/%b/%b",
                     $time, anode, seg, dp, scan_done,
                     e_an, e_seg, e_dp, e_done);
          end
        end
      end
    join_none

    en    = 1'b1;
    value = 16'h0000;
    dp_in = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    lit("reset_out", 4'hF, 7'h7F, 1'b1);
    lit_done("reset_done", 1'b0);
    chk_on = 1'b1;

    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    lit("first_edge", 4'hE, 7'h40, 1'b1);
    value = 16'h12AF;

    step(15);
    lit_done("done_e16", 1'b1);
    step(1);
    lit_done("done_e17", 1'b0);
    lit("f2_d0", 4'hE, 7'h0E, 1'b1);
    step(4);
    lit("f2_d1", 4'hD, 7'h08, 1'b1);
    step(4);
    lit("f2_d2", 4'hB, 7'h24, 1'b1);
    step(4);
    lit("f2_d3", 4'h7, 7'h79, 1'b1);
    step(3);
    lit_done("done_e32", 1'b1);

    step(5);
    lit("f3_d1", 4'hD, 7'h08, 1'b1);
    value = 16'h3333;
    step(4);
    lit("tear_d2", 4'hB, 7'h24, 1'b1);
    step(4);
    lit("tear_d3", 4'h7, 7'h79, 1'b1);
    step(4);
    lit("new_d0", 4'hE, 7'h30, 1'b1);

    step(9);
    lit("pre_drop", 4'hB, 7'h30, 1'b1);
    en = 1'b0;
    step(1);
    lit("dis_blank", 4'hF, 7'h7F, 1'b1);
    step(1);
    value = 16'h12AF;
    step(8);
    lit("dis_hold", 4'hF, 7'h7F, 1'b1);
    en = 1'b1;
    step(1);
    lit("relit_a", 4'hB, 7'h24, 1'b1);
    step(1);
    lit("relit_b", 4'hB, 7'h24, 1'b1);
    step(1);
    lit("after_relit", 4'h7, 7'h79, 1'b1);
    dp_in = 4'b0100;

    step(8);
    lit("dp_d1", 4'hD, 7'h08, 1'b1);
    step(4);
    lit("dp_d2", 4'hB, 7'h24, 1'b0);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst", 4'hF, 7'h7F, 1'b1);
    lit_done("async_done", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    lit("restart", 4'hE, 7'h40, 1'b1);
    step(4);
    lit("restart_d1", 4'hD, 7'h08, 1'b1);
    value = 16'h0050;
    dp_in = 4'h0;

    step(12);
    lit("lz_d0", 4'hE, 7'h40, 1'b1);
    step(4);
    lit("lz_d1", 4'hD, 7'h12, 1'b1);
    step(4);
`ifdef SSD_LZ_BLANK_EN
    lit("lz_d2", 4'hB, 7'h7F, 1'b1);
`else
    lit("lz_d2", 4'hB, 7'h40, 1'b1);
`endif
    step(4);
`ifdef SSD_LZ_BLANK_EN
    lit("lz_d3", 4'h7, 7'h7F, 1'b1);
`else
    lit("lz_d3", 4'h7, 7'h40, 1'b1);
`endif
    step(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
